// File: rtl/press_classify_pkg.sv
// Shared definitions for the touch gesture classifier: FSM state encodings,
// event codes and the millisecond counter helpers.
package press_classify_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DOWN1 = 3'd1,
    ST_GAP   = 3'd2,
    ST_DOWN2 = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_DOUBLE = 2'd2,
    EV_LONG   = 2'd3
  } event_e;

  localparam int         MS_W   = 10;
  localparam logic [9:0] MS_MAX = 10'd1023;

  // Saturating increment: the ms counter must never wrap back to a
  // small value, or a long hold could re-trigger a threshold compare.
  function automatic logic [MS_W-1:0] ms_sat_inc(input logic [MS_W-1:0] val);
    if (val == MS_MAX) begin
      return val;
    end else begin
      return val + 10'd1;
    end
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: emits a one-cycle tick every TICK_MAX clocks.
// A clear restarts the count so each FSM state measures time from entry.
module ms_tick_gen #(
  parameter int TICK_MAX = 50000
) (
  input  logic clk_out,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam logic [CW-1:0] PRE_LAST = CW'(TICK_MAX - 1);

  logic [CW-1:0] pre_r;

  // Prescaler counts 0..TICK_MAX-1, restarting on clear or wrap.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
    end else if (clr) begin
      pre_r <= '0;
    end else if (pre_r == PRE_LAST) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + CW'(1);
    end
  end

  // Tick is a pure decode of the prescaler register; a clear suppresses it.
  assign tick = (pre_r == PRE_LAST) && !clr;

endmodule

// File: rtl/press_classify.sv
// Gesture classifier: turns the debounced touch level into exactly one
// single-cycle short, double or long press event per gesture.
module press_classify
  import press_classify_pkg::*;
#(
  parameter int TICK_MAX  = 50000,
  parameter int LONG_MS   = 800,
  parameter int DOUBLE_MS = 300
) (
  input  logic       clk_out,
  input  logic       rst,
  input  logic       btn_debounce,
  output logic       short_press,
  output logic       double_press,
  output logic       long_press,
  output logic [1:0] last_event,
  output logic       busy
);

  localparam logic [MS_W-1:0] LONG_CNT   = MS_W'(LONG_MS);
  localparam logic [MS_W-1:0] DOUBLE_CNT = MS_W'(DOUBLE_MS);

  logic            btn_q_r;
  logic            rise_s;
  logic            fall_s;
  logic            tick_s;
  logic            clr_s;
  logic            long_hit_s;
  logic            gap_hit_s;
  logic [MS_W-1:0] ms_cnt_r;
  state_e          state_r;
  state_e          state_s;
  event_e          ev_s;
  event_e          ev_pend_r;

  assign rise_s     = btn_debounce & ~btn_q_r;
  assign fall_s     = ~btn_debounce & btn_q_r;
  assign long_hit_s = (ms_cnt_r == LONG_CNT);
  assign gap_hit_s  = (ms_cnt_r == DOUBLE_CNT);
  assign clr_s      = (state_s != state_r);

  ms_tick_gen #(
    .TICK_MAX (TICK_MAX)
  ) u_tick (
    .clk_out (clk_out),
    .rst     (rst),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // Edge-detect register for the debounced button level.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      btn_q_r <= 1'b0;
    end else begin
      btn_q_r <= btn_debounce;
    end
  end

  // Millisecond counter: restarts on every state change, saturates at max.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      ms_cnt_r <= '0;
    end else if (clr_s) begin
      ms_cnt_r <= '0;
    end else if (tick_s) begin
      ms_cnt_r <= ms_sat_inc(ms_cnt_r);
    end
  end

  // Next-state and event decode; edges win over timeouts in the same cycle.
  always_comb begin
    state_s = state_r;
    ev_s    = EV_NONE;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          state_s = ST_DOWN1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_DOWN1: begin
        if (fall_s) begin
          state_s = ST_GAP;
        end else if (long_hit_s) begin
          state_s = ST_HOLD;
          ev_s    = EV_LONG;
        end else begin
          state_s = ST_DOWN1;
        end
      end
      ST_GAP: begin
        if (rise_s) begin
          state_s = ST_DOWN2;
        end else if (gap_hit_s) begin
          state_s = ST_IDLE;
          ev_s    = EV_SHORT;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_DOWN2: begin
        if (fall_s) begin
          state_s = ST_IDLE;
          ev_s    = EV_DOUBLE;
        end else if (long_hit_s) begin
          state_s = ST_HOLD;
          ev_s    = EV_LONG;
        end else begin
          state_s = ST_DOWN2;
        end
      end
      ST_HOLD: begin
        if (fall_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ev_s    = EV_NONE;
      end
    endcase
  end

  // State register and one-deep event stage feeding the output registers.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      ev_pend_r <= EV_NONE;
    end else begin
      state_r   <= state_s;
      ev_pend_r <= ev_s;
    end
  end

  // Registered outputs: pulses and busy align, last_event holds the latest code.
  always_ff @(posedge clk_out or negedge rst) begin
    if (!rst) begin
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      last_event   <= 2'd0;
      busy         <= 1'b0;
    end else begin
      short_press  <= (ev_pend_r == EV_SHORT);
      double_press <= (ev_pend_r == EV_DOUBLE);
      long_press   <= (ev_pend_r == EV_LONG);
      busy         <= (state_r != ST_IDLE);
      if (ev_pend_r != EV_NONE) begin
        last_event <= ev_pend_r;
      end
    end
  end

endmodule
